// File: rtl/branch_resolve_b_pkg.sv
// Shared types and constants for the B-stage branch resolver.
// Holds the 2-bit BHT counter encodings, the BHT reset state and the default
// table size.
package branch_resolve_b_pkg;

    // 2-bit saturating predictor states
    typedef enum logic [1:0] {
        SNT = 2'b00,   // strongly not-taken
        WNT = 2'b01,   // weakly not-taken
        WT  = 2'b10,   // weakly taken
        ST  = 2'b11    // strongly taken
    } bht_state_e;

    localparam bht_state_e BHT_RESET     = WNT;
    localparam int         DEFAULT_IDX_W = 4;

endpackage

// File: rtl/branch_resolve_b_sat_counter2.sv
// Saturating 2-bit predictor counter update.
// Purely combinational: the next state is available in the same cycle.
// Ports: cur_i current state, taken_i resolved direction, nxt_o next state.
module sat_counter2
    import branch_resolve_b_pkg::*;
(
    input  bht_state_e cur_i,
    input  logic       taken_i,
    output bht_state_e nxt_o
);

    always_comb begin
        nxt_o = cur_i;
        if (taken_i) begin
            if (cur_i != ST) begin
                nxt_o = bht_state_e'(cur_i + 2'd1);
            end
        end else begin
            if (cur_i != SNT) begin
                nxt_o = bht_state_e'(cur_i - 2'd1);
            end
        end
    end

endmodule

// File: rtl/branch_resolve_b.sv
// B-stage branch resolution with a 2-bit BHT predictor and statistics counters.
// Lookup (PredTakenF), FlushB and RedirectPCB are combinational; BHT and counters
// update on posedge clk. StallB holds all state and suppresses the flush.
// Ports: clk/reset; PCF -> PredTakenF (fetch lookup); BranchB, JumpB, PCSrcB1,
// CondTakenB, PCB, PCTargetB, PCPlus4B, StallB (B-stage resolve inputs);
// FlushB, RedirectPCB (mispredict recovery); BranchCnt, MispredCnt (stats).
module branch_resolve_b
    import branch_resolve_b_pkg::*;
#(
    parameter int IDX_W = DEFAULT_IDX_W,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       PCF,
    output logic              PredTakenF,
    input  logic              BranchB,
    input  logic              JumpB,
    input  logic              PCSrcB1,
    input  logic              CondTakenB,
    input  logic [31:0]       PCB,
    input  logic [31:0]       PCTargetB,
    input  logic [31:0]       PCPlus4B,
    input  logic              StallB,
    output logic              FlushB,
    output logic [31:0]       RedirectPCB,
    output logic [CNT_W-1:0]  BranchCnt,
    output logic [CNT_W-1:0]  MispredCnt
);

    localparam int               NUM_ENT = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Flip-flop array so every entry can be cleared in a single reset edge
    logic [1:0] bht_q [NUM_ENT];
    logic [1:0] bht_d [NUM_ENT];

    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0] lkp_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [1:0]       lkp_ent;
    logic             actual_taken;
    logic             resolve;
    logic             mispredict;
    logic             upd_en;
    bht_state_e       upd_nxt;

    assign lkp_idx = PCF[IDX_W+1:2];
    assign upd_idx = PCB[IDX_W+1:2];

    // Reads the registered table, so a same-index update this cycle is not seen
    assign lkp_ent    = bht_q[lkp_idx];
    assign PredTakenF = lkp_ent[1];

    assign actual_taken = JumpB | (BranchB & CondTakenB);
    assign resolve      = (BranchB | JumpB) & ~StallB;
    assign mispredict   = resolve & (actual_taken != PCSrcB1);
    assign upd_en       = BranchB & ~StallB;

    assign FlushB      = mispredict;
    assign RedirectPCB = (mispredict && actual_taken) ? PCTargetB : PCPlus4B;

    sat_counter2 u_sat (
        .cur_i   (bht_state_e'(bht_q[upd_idx])),
        .taken_i (CondTakenB),
        .nxt_o   (upd_nxt)
    );

    always_comb begin
        for (int i = 0; i < NUM_ENT; i++) begin
            bht_d[i] = bht_q[i];
        end
        if (upd_en) begin
            bht_d[upd_idx] = upd_nxt;
        end
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (resolve && (branch_cnt_q != CNT_MAX)) begin
            branch_cnt_d = branch_cnt_q + 1'b1;
        end
        if (mispredict && (mispred_cnt_q != CNT_MAX)) begin
            mispred_cnt_d = mispred_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                bht_q[i] <= BHT_RESET;
            end
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_ENT; i++) begin
                bht_q[i] <= bht_d[i];
            end
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign BranchCnt  = branch_cnt_q;
    assign MispredCnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_b.sv
// Self-checking bench for branch_resolve_b against a behavioural model.
// Inputs change just after negedge; outputs are sampled 1 time unit later.
// Uses a narrow counter width so saturation is reachable quickly.
module tb_branch_resolve_b;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   PCF;
    logic          PredTakenF;
    logic          BranchB, JumpB, PCSrcB1, CondTakenB, StallB;
    logic [31:0]   PCB, PCTargetB, PCPlus4B;
    logic          FlushB;
    logic [31:0]   RedirectPCB;
    logic [CW-1:0] BranchCnt, MispredCnt;

    int total = 0;
    int bad   = 0;

    // Model state: counter value 0..3 per entry, plain integer statistics
    int m_bht [16];
    int m_bc;
    int m_mc;

    always #5 clk = ~clk;

    branch_resolve_b #(.IDX_W(4), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .PCF         (PCF),
        .PredTakenF  (PredTakenF),
        .BranchB     (BranchB),
        .JumpB       (JumpB),
        .PCSrcB1     (PCSrcB1),
        .CondTakenB  (CondTakenB),
        .PCB         (PCB),
        .PCTargetB   (PCTargetB),
        .PCPlus4B    (PCPlus4B),
        .StallB      (StallB),
        .FlushB      (FlushB),
        .RedirectPCB (RedirectPCB),
        .BranchCnt   (BranchCnt),
        .MispredCnt  (MispredCnt)
    );

    function automatic int idx_of(input logic [31:0] pc);
        return int'(pc[5:2]);
    endfunction

    function automatic logic exp_mispred();
        logic actual;
        actual = JumpB | (BranchB & CondTakenB);
        return (BranchB | JumpB) && (actual != PCSrcB1) && !StallB;
    endfunction

    function automatic logic [31:0] exp_redirect();
        logic actual;
        actual = JumpB | (BranchB & CondTakenB);
        if (exp_mispred() && actual) return PCTargetB;
        return PCPlus4B;
    endfunction

    function automatic logic exp_pred();
        return m_bht[idx_of(PCF)] >= 2;
    endfunction

    task automatic set_idle();
        reset = 1'b0; BranchB = 1'b0; JumpB = 1'b0; PCSrcB1 = 1'b0;
        CondTakenB = 1'b0; StallB = 1'b0; PCF = 32'h0; PCB = 32'h0;
        PCTargetB = 32'h0; PCPlus4B = 32'h4;
    endtask

    // One clock edge; the model follows the rules on the inputs held across it
    task automatic tick();
        int  k;
        logic mp;
        mp = exp_mispred();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 16; i++) m_bht[i] = 1;
            m_bc = 0;
            m_mc = 0;
        end else if (!StallB) begin
            if (BranchB) begin
                k = idx_of(PCB);
                if (CondTakenB) m_bht[k] = (m_bht[k] == 3) ? 3 : m_bht[k] + 1;
                else            m_bht[k] = (m_bht[k] == 0) ? 0 : m_bht[k] - 1;
            end
            if ((BranchB || JumpB) && m_bc < CMAX) m_bc++;
            if (mp && m_mc < CMAX) m_mc++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        PCF = 32'h10;
        #1;
        total++;
        if (PredTakenF !== 1'b0) begin
            bad++; $display("FAIL reset_pred0x10 got=%0b want=0", PredTakenF);
        end
        total++;
        if (BranchCnt !== '0) begin
            bad++; $display("FAIL reset_branchcnt got=%0d want=0", BranchCnt);
        end
        total++;
        if (MispredCnt !== '0) begin
            bad++; $display("FAIL reset_mispredcnt got=%0d want=0", MispredCnt);
        end
        for (int i = 0; i < 16; i++) begin
            PCF = 32'(i << 2);
            #1;
            total++;
            if (PredTakenF !== exp_pred()) begin
                bad++; $display("FAIL reset_bht[%0d] got=%0b want=%0b", i, PredTakenF, exp_pred());
            end
        end
    endtask

    task automatic test_taken_seq();
        for (int k = 0; k < 3; k++) begin
            BranchB = 1'b1; CondTakenB = 1'b1; PCB = 32'h10;
            PCTargetB = 32'h80; PCPlus4B = 32'h14; PCF = 32'h10;
            PCSrcB1 = (k == 2);
            #1;
            total++;
            if (FlushB !== exp_mispred()) begin
                bad++; $display("FAIL taken_seq_flush[%0d] got=%0b want=%0b", k, FlushB, exp_mispred());
            end
            total++;
            if (RedirectPCB !== exp_redirect()) begin
                bad++; $display("FAIL taken_seq_redirect[%0d] got=%h want=%h", k, RedirectPCB, exp_redirect());
            end
            total++;
            if (PredTakenF !== exp_pred()) begin
                bad++; $display("FAIL taken_seq_pred[%0d] got=%0b want=%0b", k, PredTakenF, exp_pred());
            end
            tick();
        end
        set_idle();
        PCF = 32'h10;
        #1;
        total++;
        if (PredTakenF !== 1'b1) begin
            bad++; $display("FAIL taken_seq_final_pred got=%0b want=1", PredTakenF);
        end
        total++;
        if (MispredCnt !== CW'(2)) begin
            bad++; $display("FAIL taken_seq_mispredcnt got=%0d want=2", MispredCnt);
        end
        total++;
        if (BranchCnt !== CW'(m_bc)) begin
            bad++; $display("FAIL taken_seq_branchcnt got=%0d want=%0d", BranchCnt, m_bc);
        end
    endtask

    task automatic test_jump();
        JumpB = 1'b1; PCSrcB1 = 1'b0; PCTargetB = 32'h200; PCPlus4B = 32'h24;
        PCB = 32'h20; PCF = 32'h20;
        #1;
        total++;
        if (FlushB !== 1'b1) begin
            bad++; $display("FAIL jump_flush got=%0b want=1", FlushB);
        end
        total++;
        if (RedirectPCB !== 32'h200) begin
            bad++; $display("FAIL jump_redirect got=%h want=00000200", RedirectPCB);
        end
        tick();
        set_idle();
        PCF = 32'h20;
        #1;
        total++;
        if (PredTakenF !== exp_pred()) begin
            bad++; $display("FAIL jump_bht_unchanged got=%0b want=%0b", PredTakenF, exp_pred());
        end
        total++;
        if (MispredCnt !== CW'(m_mc)) begin
            bad++; $display("FAIL jump_mispredcnt got=%0d want=%0d", MispredCnt, m_mc);
        end
    endtask

    task automatic test_nt_mispredict();
        BranchB = 1'b1; CondTakenB = 1'b0; PCSrcB1 = 1'b1;
        PCB = 32'h40; PCTargetB = 32'h300; PCPlus4B = 32'h44;
        #1;
        total++;
        if (FlushB !== 1'b1) begin
            bad++; $display("FAIL nt_flush got=%0b want=1", FlushB);
        end
        total++;
        if (RedirectPCB !== 32'h44) begin
            bad++; $display("FAIL nt_redirect got=%h want=00000044", RedirectPCB);
        end
        tick();
        set_idle();
        #1;
        total++;
        if (MispredCnt !== CW'(m_mc)) begin
            bad++; $display("FAIL nt_mispredcnt got=%0d want=%0d", MispredCnt, m_mc);
        end
    endtask

    task automatic test_stall();
        int bc0, mc0;
        bc0 = m_bc; mc0 = m_mc;
        // Push entry 9 to weakly taken once released, observable via PredTakenF
        for (int k = 0; k < 4; k++) begin
            BranchB = 1'b1; CondTakenB = 1'b1; PCSrcB1 = 1'b0;
            PCB = 32'h24; PCTargetB = 32'h400; PCPlus4B = 32'h28; PCF = 32'h24;
            StallB = (k < 3);
            #1;
            total++;
            if (FlushB !== exp_mispred()) begin
                bad++; $display("FAIL stall_flush[%0d] got=%0b want=%0b", k, FlushB, exp_mispred());
            end
            total++;
            if (PredTakenF !== exp_pred()) begin
                bad++; $display("FAIL stall_pred[%0d] got=%0b want=%0b", k, PredTakenF, exp_pred());
            end
            total++;
            if (MispredCnt !== CW'(mc0) || BranchCnt !== CW'(bc0)) begin
                bad++; $display("FAIL stall_cnt[%0d] got=%0d/%0d want=%0d/%0d",
                                k, BranchCnt, MispredCnt, bc0, mc0);
            end
            tick();
        end
        set_idle();
        PCF = 32'h24;
        #1;
        total++;
        if (PredTakenF !== 1'b1) begin
            bad++; $display("FAIL stall_release_pred got=%0b want=1", PredTakenF);
        end
        total++;
        if (MispredCnt !== CW'(m_mc)) begin
            bad++; $display("FAIL stall_release_mispredcnt got=%0d want=%0d", MispredCnt, m_mc);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        // Train entry 2 to strongly taken
        for (int k = 0; k < 2; k++) begin
            BranchB = 1'b1; CondTakenB = 1'b1; PCSrcB1 = 1'b1; PCB = 32'h08;
            tick();
        end
        set_idle();
        for (int k = 0; k < CMAX + 5; k++) begin
            JumpB = 1'b1; PCSrcB1 = 1'b0; PCTargetB = 32'h500;
            tick();
        end
        set_idle();
        #1;
        total++;
        if (MispredCnt !== CW'(CMAX)) begin
            bad++; $display("FAIL sat_mispredcnt got=%0d want=%0d", MispredCnt, CMAX);
        end
        total++;
        if (BranchCnt !== CW'(CMAX)) begin
            bad++; $display("FAIL sat_branchcnt got=%0d want=%0d", BranchCnt, CMAX);
        end
        PCF = 32'h08;
        #1;
        total++;
        if (PredTakenF !== 1'b1) begin
            bad++; $display("FAIL sat_trained_pred got=%0b want=1", PredTakenF);
        end
        // Mispredicting branch on entry 2 while reset is asserted
        reset = 1'b1; BranchB = 1'b1; CondTakenB = 1'b0; PCSrcB1 = 1'b1;
        PCB = 32'h08; PCPlus4B = 32'h0C;
        #1;
        total++;
        if (FlushB !== exp_mispred() || RedirectPCB !== exp_redirect()) begin
            bad++; $display("FAIL sat_reset_comb got=%0b/%h want=%0b/%h",
                            FlushB, RedirectPCB, exp_mispred(), exp_redirect());
        end
        tick();
        set_idle();
        PCF = 32'h08;
        #1;
        total++;
        if (BranchCnt !== '0 || MispredCnt !== '0) begin
            bad++; $display("FAIL sat_reset_cnt got=%0d/%0d want=0/0", BranchCnt, MispredCnt);
        end
        total++;
        if (PredTakenF !== 1'b0) begin
            bad++; $display("FAIL sat_reset_pred got=%0b want=0", PredTakenF);
        end
    endtask

    task automatic test_random();
        int sel;
        for (int n = 0; n < 400; n++) begin
            sel        = int'($urandom_range(0, 3));
            reset      = ($urandom_range(0, 49) == 0);
            BranchB    = (sel == 1 || sel == 2);
            JumpB      = (sel == 3);
            CondTakenB = 1'($urandom_range(0, 1));
            PCSrcB1    = 1'($urandom_range(0, 1));
            StallB     = ($urandom_range(0, 4) == 0);
            PCB        = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            PCF        = ($urandom_range(0, 3) == 0) ? PCB
                         : {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            PCTargetB  = $urandom;
            PCPlus4B   = PCB + 32'd4;
            #1;
            total++;
            if (FlushB !== exp_mispred()) begin
                bad++; $display("FAIL rnd_flush[%0d] got=%0b want=%0b", n, FlushB, exp_mispred());
            end
            total++;
            if (RedirectPCB !== exp_redirect()) begin
                bad++; $display("FAIL rnd_redirect[%0d] got=%h want=%h", n, RedirectPCB, exp_redirect());
            end
            total++;
            if (PredTakenF !== exp_pred()) begin
                bad++; $display("FAIL rnd_pred[%0d] got=%0b want=%0b", n, PredTakenF, exp_pred());
            end
            total++;
            if (BranchCnt !== CW'(m_bc) || MispredCnt !== CW'(m_mc)) begin
                bad++; $display("FAIL rnd_cnt[%0d] got=%0d/%0d want=%0d/%0d",
                                n, BranchCnt, MispredCnt, m_bc, m_mc);
            end
            tick();
        end
        set_idle();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_bht[i] = 1;
        m_bc = 0;
        m_mc = 0;
        set_idle();
        @(negedge clk);
        test_reset();
        test_taken_seq();
        test_jump();
        test_nt_mispredict();
        test_stall();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve_b.md
BRANCH_RESOLVE_B -- requirements
Module: branch_resolve_b

Interface
REQ-001 The module SHALL expose parameter IDX_W, default 4, meaning log2 of branch-history-table (BHT) entries.
REQ-002 The module SHALL expose parameter CNT_W, default 16, meaning width of the statistics counters.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 PCF  in  32  fetch-stage PC for the prediction lookup.
REQ-006 PredTakenF  out  1  fetch prediction, taken when the indexed counter MSB = 1.
REQ-007 BranchB, JumpB  in  1 each  B-stage control from the E->B pipeline register.
REQ-008 PCSrcB1  in  1  prediction carried down the pipe for this B-stage instruction.
REQ-009 CondTakenB  in  1  resolved branch condition.
REQ-010 PCB, PCTargetB, PCPlus4B  in  32 each  B-stage PC, taken target, fall-through.
REQ-011 StallB  in  1  B stage held; no state update.
REQ-012 FlushB  out  1  mispredict; clears the upstream E->B and earlier pipeline registers.
REQ-013 RedirectPCB  out  32  corrected fetch PC; valid when FlushB = 1.
REQ-014 BranchCnt, MispredCnt  out  CNT_W each  resolved-branch and mispredict statistics.

Function
REQ-015 Index SHALL be PCF[IDX_W+1:2] for lookup and PCB[IDX_W+1:2] for update.
REQ-016 PredTakenF SHALL be combinational from the BHT state (zero-cycle lookup).
REQ-017 ActualTaken SHALL be JumpB | (BranchB & CondTakenB).
REQ-018 Mispredict SHALL be (BranchB | JumpB) & (ActualTaken != PCSrcB1) & ~StallB.
REQ-019 FlushB SHALL equal Mispredict combinationally in the same cycle.
REQ-020 RedirectPCB SHALL be PCTargetB when ActualTaken = 1, else PCPlus4B.
REQ-021 RedirectPCB SHALL be PCPlus4B when FlushB = 0.
REQ-022 On a clock edge with BranchB & ~StallB, BHT[PCB index] SHALL increment when CondTakenB = 1 and decrement when CondTakenB = 0.
REQ-023 The increment SHALL saturate at 2'b11 and the decrement SHALL saturate at 2'b00.
REQ-024 Jumps SHALL NOT update the BHT.
REQ-025 When the lookup and update indices match in the same cycle, PredTakenF SHALL return the pre-update value.
REQ-026 BranchCnt SHALL increment on each edge with (BranchB | JumpB) & ~StallB.
REQ-027 MispredCnt SHALL increment on each edge with Mispredict.
REQ-028 Both statistics counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-029 A bubble (all control bits 0, from the E->B register clear) SHALL produce no flush, no BHT update and no counter change.

Reset
REQ-030 While reset = 1 at a clock edge, every BHT entry SHALL become 2'b01 (weakly not-taken).
REQ-031 While reset = 1 at a clock edge, BranchCnt and MispredCnt SHALL become 0.
REQ-032 Reset SHALL dominate any simultaneous update.
REQ-033 A branch present in B during reset SHALL leave no trace in the BHT or the statistics counters.
REQ-034 FlushB and RedirectPCB SHALL follow REQ-019/020 from their inputs during reset; the E->B register reset guarantees a bubble.

Structure
REQ-035 A shared package SHALL hold the 2-bit counter encodings (SNT=00, WNT=01, WT=10, ST=11), BHT_RESET = WNT, and the default IDX_W.
REQ-036 The saturating 2-bit update SHALL be a sub-module sat_counter2 (inputs: cur state, taken; output: next state).
REQ-037 The BHT SHALL be a flip-flop array, not inferred RAM, so that the REQ-030 reset holds.

Verification
REQ-038 After reset, lookup at PCF=0x10 -> PredTakenF=0; BranchCnt=0; MispredCnt=0.
REQ-039 Three taken branches at PCB=0x10 with PCSrcB1=0,0,1 -> BHT[4] goes 01->10->11->11; FlushB=1,1,0; MispredCnt=2.
REQ-040 JumpB=1, PCSrcB1=0, PCTargetB=0x200 -> FlushB=1, RedirectPCB=0x200, BHT unchanged.
REQ-041 Not-taken mispredict: PCSrcB1=1, CondTakenB=0, PCPlus4B=0x44 -> FlushB=1, RedirectPCB=0x44.
REQ-042 Mispredicting branch with StallB=1 -> FlushB=0 and no BHT or counter change until the cycle StallB falls.
REQ-043 Force counters to all-ones, then issue a mispredict -> both counters remain all-ones; reset mid-sequence -> counters 0 and BHT entries 01 on the next edge.
